// File: rtl/bram_dump_uart_pkg.sv
// Shared types and constants for the BRAM-to-UART dump path.
// Holds the dump FSM state type, UART frame constants and the sample sign-extension helper.
package bram_dump_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StRdReq,
        StRdWait,
        StTxLo,
        StTxHi,
        StFin
    } dump_state_e;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned UART_FRAME_BITS   = 10;
    localparam logic        UART_IDLE         = 1'b1;

    // Sign-extend the nb LSBs of raw to a full 16-bit word; bits above nb are discarded.
    function automatic logic [15:0] sext16(input logic [15:0] raw, input int unsigned nb);
        logic [15:0] mask;
        logic        sign;
        mask = 16'hFFFF << nb;
        sign = |(raw & (16'h0001 << (nb - 1)));
        return sign ? (raw | mask) : (raw & ~mask);
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter with a registered line output.
// A new byte is accepted in the last cycle of the previous stop bit, so frames run back-to-back.
module uart_tx_byte
    import bram_dump_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_done
);

    localparam int unsigned NbBaud = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [NbBaud-1:0] BaudLast = NbBaud'(BAUD_DIV - 1);
    localparam logic [3:0]        BitLast  = 4'(UART_FRAME_BITS - 1);

    logic [NbBaud-1:0]          baud_q, baud_d;
    logic [3:0]                 bit_q, bit_d;
    logic [UART_FRAME_BITS-1:0] frame_q, frame_d;
    logic                       tx_q, tx_d;
    logic                       busy_q, busy_d;
    logic                       bit_end;
    logic                       frame_end;

    always_comb begin
        bit_end   = busy_q && (baud_q == BaudLast);
        frame_end = bit_end && (bit_q == BitLast);
        o_done    = frame_end;
        o_ready   = !busy_q || frame_end;

        baud_d  = baud_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        tx_d    = tx_q;
        busy_d  = busy_q;

        if (busy_q) begin
            if (bit_end) begin
                baud_d = '0;
                if (frame_end) begin
                    busy_d = 1'b0;
                    tx_d   = UART_IDLE;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    // tx always mirrors frame[0]; shift in idle so the stop bit follows the data
                    frame_d = {UART_IDLE, frame_q[UART_FRAME_BITS-1:1]};
                    tx_d    = frame_q[1];
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end

        if (i_valid && o_ready) begin
            busy_d  = 1'b1;
            baud_d  = '0;
            bit_d   = '0;
            frame_d = {UART_IDLE, i_byte, 1'b0};
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            baud_q  <= '0;
            bit_q   <= '0;
            frame_q <= '1;
            tx_q    <= UART_IDLE;
            busy_q  <= 1'b0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign o_tx = tx_q;

endmodule

// File: rtl/bram_dump_uart.sv
// Dumps N_SAMPLES BRAM words over UART: sync header, then each sample sign-extended to 16 bits,
// low byte first. Holds the dump FSM, the address counter and the sample high-byte register.
module bram_dump_uart
    import bram_dump_uart_pkg::*;
#(
    parameter int unsigned NB_ADDR   = 11,
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned NB_SAMPLE = 13,
    parameter int unsigned N_SAMPLES = 2048,
    parameter int unsigned BAUD_DIV  = 868,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic [NB_ADDR-1:0] o_read_addr,
    output logic               o_read_enable,
    input  logic [NB_DATA-1:0] i_read_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [NB_ADDR-1:0] AddrLast = NB_ADDR'(N_SAMPLES - 1);

    dump_state_e        state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_ADDR-1:0] rd_addr_q, rd_addr_d;
    logic               rd_en_q, rd_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         sample_hi_q, sample_hi_d;

    logic               tx_valid;
    logic [7:0]         tx_byte;
    logic               tx_done;
    logic               unused_tx_ready;
    logic               unused_read_bits;
    logic [15:0]        sample_ext;

    assign unused_read_bits = ^i_read_data[NB_DATA-1:NB_SAMPLE];
    assign sample_ext       = sext16(16'(i_read_data[NB_SAMPLE-1:0]), NB_SAMPLE);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_addr_d   = rd_addr_q;
        rd_en_d     = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sample_hi_d = sample_hi_q;
        tx_valid    = 1'b0;
        tx_byte     = 8'h00;

        case (state_q)
            StIdle: begin
                // Header is handed to the transmitter on the accepting edge so its start bit
                // appears on the line the very next cycle.
                if (i_start) begin
                    tx_valid = 1'b1;
                    tx_byte  = SYNC_BYTE;
                    addr_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = StHdr;
                end
            end
            StHdr: begin
                if (tx_done) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    state_d   = StRdReq;
                end
            end
            StRdReq: begin
                state_d = StRdWait;
            end
            StRdWait: begin
                sample_hi_d = sample_ext[15:8];
                tx_valid    = 1'b1;
                tx_byte     = sample_ext[7:0];
                state_d     = StTxLo;
            end
            StTxLo: begin
                if (tx_done) begin
                    tx_valid = 1'b1;
                    tx_byte  = sample_hi_q;
                    state_d  = StTxHi;
                end
            end
            StTxHi: begin
                if (tx_done) begin
                    if (addr_q == AddrLast) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StFin;
                    end else begin
                        addr_d    = addr_q + 1'b1;
                        rd_en_d   = 1'b1;
                        rd_addr_d = addr_q + 1'b1;
                        state_d   = StRdReq;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sample_hi_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sample_hi_q <= sample_hi_d;
        end
    end

    uart_tx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart_tx (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_valid(tx_valid),
        .i_byte (tx_byte),
        .o_ready(unused_tx_ready),
        .o_tx   (o_tx),
        .o_done (tx_done)
    );

    assign o_read_addr   = rd_addr_q;
    assign o_read_enable = rd_en_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_bram_dump_uart.sv
// Directed bench for bram_dump_uart: UART line decoder, 1-cycle-latency BRAM model and
// per-scenario tasks with hand-computed expected bytes.
module tb_bram_dump_uart;

    localparam int unsigned BAUD = 4;
    localparam int unsigned NS   = 4;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [10:0] o_read_addr;
    logic        o_read_enable;
    logic [31:0] i_read_data;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [4];
    logic [7:0]  rx_q [$];
    logic [10:0] addr_log [$];
    int          done_count;
    int          frame_errs;

    bit          dec_active;
    int          dec_cnt;
    logic [7:0]  dec_shift;
    bit          dec_stop_ok;

    always #5 clk = ~clk;

    bram_dump_uart #(
        .NB_ADDR  (11),
        .NB_DATA  (32),
        .NB_SAMPLE(13),
        .N_SAMPLES(NS),
        .BAUD_DIV (BAUD),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .o_read_addr  (o_read_addr),
        .o_read_enable(o_read_enable),
        .i_read_data  (i_read_data),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always @(posedge clk) begin
        if (o_read_enable) i_read_data <= mem[o_read_addr[1:0]];
    end

    // Line decoder: start cycle is dec_cnt 0, bit k spans 4k..4k+3, sampled at 4k+2.
    always @(negedge clk) begin
        if (i_rst) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (o_tx === 1'b0) begin
                dec_active  = 1'b1;
                dec_cnt     = 0;
                dec_shift   = 8'h00;
                dec_stop_ok = 1'b1;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt < 4 && o_tx !== 1'b0) dec_stop_ok = 1'b0;
            if (dec_cnt >= 6 && dec_cnt <= 34 && (dec_cnt % 4) == 2)
                dec_shift = {o_tx, dec_shift[7:1]};
            if (dec_cnt >= 36 && o_tx !== 1'b1) dec_stop_ok = 1'b0;
            if (dec_cnt == 39) begin
                rx_q.push_back(dec_shift);
                if (!dec_stop_ok) frame_errs++;
                dec_active = 1'b0;
            end
        end
        if (!i_rst && o_read_enable === 1'b1) addr_log.push_back(o_read_addr);
        if (o_done === 1'b1) done_count++;
    end

    task automatic clear_logs();
        rx_q.delete();
        addr_log.delete();
        done_count = 0;
        frame_errs = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        seen = (o_done === 1'b1);
        repeat (50) @(negedge clk);
    endtask

    task automatic test_reset();
        i_rst   = 1'b1;
        i_start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (o_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", o_tx); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++;
        if (o_read_enable !== 1'b0) begin
            errors++; $display("FAIL reset_rd_en: got %b want 0", o_read_enable);
        end
        checks++;
        if (o_read_addr !== 11'd0) begin
            errors++; $display("FAIL reset_addr: got %0d want 0", o_read_addr);
        end
        i_rst   = 1'b0;
        i_start = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_tx !== 1'b1) begin
            errors++; $display("FAIL reset_start_dropped: busy=%b tx=%b want 0 1", o_busy, o_tx);
        end
    endtask

    task automatic test_full_dump();
        logic [7:0] exp_b [9] = '{8'hA5, 8'h05, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'hF0};
        logic [7:0] got;
        int cyc, low_run, busy_low;
        mem[0] = 32'h0000_0005;
        mem[1] = 32'h0000_1FFF;
        mem[2] = 32'h0000_0FFF;
        mem[3] = 32'h0000_1000;
        clear_logs();
        @(negedge clk);
        i_start = 1'b1;
        checks++;
        if (o_tx !== 1'b1) begin errors++; $display("FAIL pre_start_tx: got %b want 1", o_tx); end
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1;
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b want 1", o_busy); end
        low_run = 0;
        while (o_tx === 1'b0 && low_run < 10) begin
            low_run++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (low_run != 4) begin
            errors++; $display("FAIL first_start_bit_len: got %0d want 4", low_run);
        end
        busy_low = 0;
        while (o_done !== 1'b1 && cyc < 1000) begin
            if (o_busy !== 1'b1) busy_low++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (o_done !== 1'b1 || cyc < 360 || cyc > 370) begin
            errors++; $display("FAIL run_length: got %0d cycles want 360..370", cyc);
        end
        checks++;
        if (busy_low != 0) begin
            errors++; $display("FAIL busy_during_run: got %0d low cycles want 0", busy_low);
        end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b want 0", o_busy); end
        repeat (50) @(negedge clk);
        checks++;
        if (rx_q.size() != 9) begin
            errors++; $display("FAIL byte_count: got %0d want 9", rx_q.size());
        end
        for (int i = 0; i < 9; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_b[i]) begin
                errors++; $display("FAIL dump_byte[%0d]: got %h want %h", i, got, exp_b[i]);
            end
        end
        checks++;
        if (done_count != 1) begin
            errors++; $display("FAIL done_pulses: got %0d want 1", done_count);
        end
        checks++;
        if (addr_log.size() != 4) begin
            errors++; $display("FAIL read_count: got %0d want 4", addr_log.size());
        end
        for (int i = 0; i < addr_log.size() && i < 4; i++) begin
            checks++;
            if (addr_log[i] !== 11'(i)) begin
                errors++; $display("FAIL read_addr[%0d]: got %0d want %0d", i, addr_log[i], i);
            end
        end
        checks++;
        if (frame_errs != 0) begin
            errors++; $display("FAIL framing: got %0d bad frames want 0", frame_errs);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        bit seen;
        clear_logs();
        pulse_start();
        n = 0;
        while (rx_q.size() < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        pulse_start();
        wait_done(seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL busy_start_done: got timeout want o_done"); end
        repeat (100) @(negedge clk);
        checks++;
        if (rx_q.size() != 9) begin
            errors++; $display("FAIL busy_start_bytes: got %0d want 9", rx_q.size());
        end
        checks++;
        if (done_count != 1) begin
            errors++; $display("FAIL busy_start_done_pulses: got %0d want 1", done_count);
        end
        checks++;
        if (addr_log.size() != 4) begin
            errors++; $display("FAIL busy_start_reads: got %0d want 4", addr_log.size());
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL busy_start_idle: got busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] exp_b [9] = '{8'hA5, 8'h05, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'hF0};
        logic [7:0] got;
        int n, tx_low;
        bit seen;
        clear_logs();
        pulse_start();
        n = 0;
        while (!(o_read_enable === 1'b1 && o_read_addr == 11'd2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (o_tx !== 1'b0) begin errors++; $display("FAIL mid_lo_start_bit: got %b want 0", o_tx); end
        i_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_tx !== 1'b1) begin errors++; $display("FAIL rst_tx_high: got %b want 1", o_tx); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        i_rst = 1'b0;
        tx_low = 0;
        repeat (60) begin
            @(negedge clk);
            if (o_tx !== 1'b1) tx_low++;
        end
        checks++;
        if (tx_low != 0) begin errors++; $display("FAIL rst_line_idle: got %0d low want 0", tx_low); end
        checks++;
        if (rx_q.size() != 5) begin
            errors++; $display("FAIL rst_partial_bytes: got %0d want 5", rx_q.size());
        end
        clear_logs();
        pulse_start();
        wait_done(seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL rerun_done: got timeout want o_done"); end
        for (int i = 0; i < 9; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_b[i]) begin
                errors++; $display("FAIL rerun_byte[%0d]: got %h want %h", i, got, exp_b[i]);
            end
        end
        checks++;
        if (addr_log.size() != 4 || addr_log[0] !== 11'd0) begin
            errors++; $display("FAIL rerun_first_addr: got n=%0d want 4 reads from 0", addr_log.size());
        end
    endtask

    task automatic test_upper_bits();
        bit seen;
        mem[0] = 32'hFFFF_E003;
        mem[1] = 32'h0000_0000;
        mem[2] = 32'h0000_0000;
        mem[3] = 32'h0000_0000;
        clear_logs();
        pulse_start();
        wait_done(seen);
        checks++;
        if (!seen || rx_q.size() != 9) begin
            errors++; $display("FAIL upper_bytes_count: got %0d want 9", rx_q.size());
        end
        checks++;
        if (rx_q.size() < 3 || rx_q[1] !== 8'h03) begin
            errors++; $display("FAIL upper_lo: got %h want 03", (rx_q.size() > 1) ? rx_q[1] : 8'hxx);
        end
        checks++;
        if (rx_q.size() < 3 || rx_q[2] !== 8'h00) begin
            errors++; $display("FAIL upper_hi: got %h want 00", (rx_q.size() > 2) ? rx_q[2] : 8'hxx);
        end
    endtask

    initial begin
        i_rst      = 1'b1;
        i_start    = 1'b0;
        dec_active = 1'b0;
        clear_logs();
        test_reset();
        test_full_dump();
        test_start_while_busy();
        test_reset_mid_byte();
        test_upper_bits();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
